seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 6; pattern length in bits, legal 2..16.
REQ-002 SHALL have parameter CNT_W, default 8; match-counter width, legal 1..16.
REQ-003 SHALL have parameter RST_PAT, default 6'b001001 (PAT_W bits); pattern loaded at reset.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port din  input  1  serial data bit.
REQ-007 SHALL have port din_valid  input  1  din is sampled only when high.
REQ-008 SHALL have port pattern  input  PAT_W  new pattern; MSB is the first bit expected.
REQ-009 SHALL have port pat_load  input  1  capture pattern on this edge.
REQ-010 SHALL have port overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-011 SHALL have port dout  output  1  Mealy match flag, combinational.
REQ-012 SHALL have port dout_q  output  1  dout registered, one cycle later.
REQ-013 SHALL have port match_cnt  output  CNT_W  saturating count of matches.
REQ-014 SHALL have port cnt_sat  output  1  high while match_cnt equals all-ones.

Function
REQ-015 SHALL hold pat_q (PAT_W), hist (PAT_W-1 most recent valid bits, newest in LSB) and fill (0..PAT_W-1 = valid bits in hist).
REQ-016 dout SHALL equal din_valid & ~pat_load & (fill == PAT_W-1) & ({hist, din} == pat_q), with no register in the path.
REQ-017 On a valid non-load cycle, hist SHALL shift left taking din, and fill SHALL increment, saturating at PAT_W-1.
REQ-018 When dout=1 and overlap_en=0, fill SHALL clear to 0 on that edge, so that the match-completing bit does not start a new match.
REQ-019 When dout=1 and overlap_en=1, history SHALL update per REQ-017, so suffix/prefix overlaps are detected.
REQ-020 When din_valid=0, hist, fill and match_cnt SHALL hold, and dout SHALL be 0.
REQ-021 pat_load=1 SHALL load pat_q from pattern and clear fill to 0; din is ignored that cycle, even if valid.
REQ-022 overlap_en SHALL be sampled every cycle with no latching; a change takes effect on the next match.
REQ-023 match_cnt SHALL increment by 1 on every edge where dout=1, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-024 dout_q SHALL register dout every cycle, giving a latency of 1.

Reset
REQ-025 While rst=0, the block SHALL force immediately, without a clock: pat_q=RST_PAT, hist=0, fill=0, match_cnt=0, dout_q=0.
REQ-026 While rst=0, dout=0 and cnt_sat=0 (for CNT_W>1).
REQ-027 A reset asserted mid-pattern SHALL discard the partial history; detection restarts from an empty history after release.
REQ-028 The first edge after rst rises SHALL be a normal functional edge.

Structure
REQ-029 A shared package SHALL hold the PAT_W/CNT_W legal-range constants and the default pattern 001001.
REQ-030 The saturating counter SHALL be a sub-module sat_counter (params W; inputs clk, rst, inc; outputs cnt, sat).
REQ-031 Illegal parameter values SHALL fail elaboration.

Verification
REQ-032 Reset, default pattern, din=0,0,1,0,0,1 valid every cycle -> dout=1 only on the 6th bit; dout_q=1 one cycle later; match_cnt=1.
REQ-033 overlap_en=1, din=001001001 -> matches on bits 6 and 9, match_cnt=2; same stream with overlap_en=0 -> match on bit 6 only, match_cnt=1.
REQ-034 din_valid low for 3 cycles inserted between bits 3 and 4 of 001001 -> match still on the 6th valid bit; dout=0 during gaps.
REQ-035 pat_load with pattern=6'b111000, then din=111000 -> match on the 6th bit; the default pattern no longer matches.
REQ-036 CNT_W=2, overlap_en=1, din=1 continuous with pattern 2'b11 (PAT_W=2) -> match_cnt reaches 3, cnt_sat=1, then holds.
REQ-037 rst pulsed low after bit 4 of 001001, then 001001 resent -> no match from the old prefix; single match at the end of the resent sequence.

Source files
------------

// File: rtl/seq_detect_param_pkg.sv
// Shared constants for the parameterised serial pattern detector.
//   PAT_W_MIN/PAT_W_MAX : legal range of the pattern length
//   CNT_W_MIN/CNT_W_MAX : legal range of the match-counter width
//   DEF_PAT             : pattern loaded at reset (first bit in MSB)
package seq_detect_param_pkg;

    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 16;
    localparam int unsigned CNT_W_MIN = 1;
    localparam int unsigned CNT_W_MAX = 16;

    localparam int unsigned DEF_PAT_W = 6;
    localparam logic [DEF_PAT_W-1:0] DEF_PAT = 6'b001001;

    // True when lo <= v <= hi.
    function automatic bit in_range(input int unsigned v,
                                    input int unsigned lo,
                                    input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter.
//   clk : clock
//   rst : asynchronous active-low reset, clears cnt
//   inc : increment request, ignored once saturated
//   cnt : current count (W bits)
//   sat : high while cnt is all-ones
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    if (W < 1) begin : g_bad_w
        $error("sat_counter: W must be at least 1");
    end

    assign sat = &cnt;

    // Count up, holding at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a loadable pattern and optional overlap.
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-low reset
//   din        : serial data bit, sampled when din_valid is high
//   din_valid  : qualifies din
//   pattern    : new pattern (MSB is the first bit expected)
//   pat_load   : capture pattern this edge; din is ignored this cycle
//   overlap_en : 1 = overlapping matches, 0 = restart after each match
//   dout       : combinational (Mealy) match flag
//   dout_q     : dout delayed by one cycle
//   match_cnt  : saturating count of matches
//   cnt_sat    : high while match_cnt is all-ones
module seq_detect_param
    import seq_detect_param_pkg::*;
#(
    parameter int unsigned      PAT_W   = 6,
    parameter int unsigned      CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             pat_load,
    input  logic             overlap_en,
    output logic             dout,
    output logic             dout_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    if (!in_range(PAT_W, PAT_W_MIN, PAT_W_MAX)) begin : g_bad_pat_w
        $error("seq_detect_param: PAT_W out of range 2..16");
    end
    if (!in_range(CNT_W, CNT_W_MIN, CNT_W_MAX)) begin : g_bad_cnt_w
        $error("seq_detect_param: CNT_W out of range 1..16");
    end

    // fill counts 0..PAT_W-1, so clog2(PAT_W) bits always suffice.
    localparam int unsigned FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  win_c;

    // Candidate window: stored history with the incoming bit appended.
    assign win_c = {hist, din};

    assign dout = din_valid & ~pat_load & (fill == FILL_FULL) & (win_c == pat_q);

    // Pattern register, shift history and fill level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= RST_PAT;
            hist  <= '0;
            fill  <= '0;
        end else if (pat_load) begin
            pat_q <= pattern;
            fill  <= '0;
        end else if (din_valid) begin
            hist <= win_c[PAT_W-2:0];
            // Non-overlapping mode discards the completing bit as a new prefix.
            if (dout && !overlap_en) begin
                fill <= '0;
            end else if (fill != FILL_FULL) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

    // One-cycle delayed match flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= 1'b0;
        end else begin
            dout_q <= dout;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (dout),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic [5:0] pattern;
    logic       pat_load;
    logic       overlap_en;
    logic       dout;
    logic       dout_q;
    logic [7:0] match_cnt;
    logic       cnt_sat;

    logic       din2;
    logic       din_valid2;
    logic [1:0] pattern2;
    logic       pat_load2;
    logic       overlap_en2;
    logic       dout2;
    logic       dout_q2;
    logic [1:0] match_cnt2;
    logic       cnt_sat2;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    seq_detect_param u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .pattern    (pattern),
        .pat_load   (pat_load),
        .overlap_en (overlap_en),
        .dout       (dout),
        .dout_q     (dout_q),
        .match_cnt  (match_cnt),
        .cnt_sat    (cnt_sat)
    );

    seq_detect_param #(
        .PAT_W   (2),
        .CNT_W   (2),
        .RST_PAT (2'b11)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .din        (din2),
        .din_valid  (din_valid2),
        .pattern    (pattern2),
        .pat_load   (pat_load2),
        .overlap_en (overlap_en2),
        .dout       (dout2),
        .dout_q     (dout_q2),
        .match_cnt  (match_cnt2),
        .cnt_sat    (cnt_sat2)
    );

    // One cycle: drive at negedge, sample the Mealy flag, then let the edge pass.
    task automatic apply(input logic d, input logic v, output logic o);
        @(negedge clk);
        din       = d;
        din_valid = v;
        #1 o = dout;
        @(posedge clk);
        #1;
    endtask

    // Send n valid bits MSB first; m collects dout per bit, aligned with bits.
    task automatic send(input logic [15:0] bits, input int n, output logic [15:0] m);
        logic o;
        m = '0;
        for (int i = n - 1; i >= 0; i--) begin
            apply(bits[i], 1'b1, o);
            m[i] = o;
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_valid = 1'b0;
        pat_load  = 1'b0;
        rst       = 1'b0;
        #2 rst    = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (match_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", match_cnt);
        end
        vectors++;
        if (dout_q !== 1'b0 || dout !== 1'b0) begin
            errors++; $display("FAIL reset_dout: got dout=%b dout_q=%b want 0/0", dout, dout_q);
        end
        vectors++;
        if (cnt_sat !== 1'b0 || cnt_sat2 !== 1'b0) begin
            errors++; $display("FAIL reset_sat: got %b/%b want 0/0", cnt_sat, cnt_sat2);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] m;
        do_reset();
        overlap_en = 1'b0;
        send(16'b001001, 6, m);
        vectors++;
        if (m[5:0] !== 6'b000001) begin
            errors++; $display("FAIL basic_dout: got %b want 000001", m[5:0]);
        end
        vectors++;
        if (match_cnt !== 8'd1) begin
            errors++; $display("FAIL basic_cnt: got %0d want 1", match_cnt);
        end
        // send() returns just after the negedge following the 6th edge.
        vectors++;
        if (dout_q !== 1'b1) begin
            errors++; $display("FAIL basic_dout_q: got %b want 1", dout_q);
        end
        @(posedge clk); #1;
        vectors++;
        if (dout_q !== 1'b0) begin
            errors++; $display("FAIL basic_dout_q_clr: got %b want 0", dout_q);
        end
    endtask

    task automatic test_overlap();
        logic [15:0] m;
        do_reset();
        overlap_en = 1'b1;
        send(16'b001001001, 9, m);
        vectors++;
        if (m[8:0] !== 9'b000001001) begin
            errors++; $display("FAIL overlap_on_dout: got %b want 000001001", m[8:0]);
        end
        vectors++;
        if (match_cnt !== 8'd2) begin
            errors++; $display("FAIL overlap_on_cnt: got %0d want 2", match_cnt);
        end
        do_reset();
        overlap_en = 1'b0;
        send(16'b001001001, 9, m);
        vectors++;
        if (m[8:0] !== 9'b000001000) begin
            errors++; $display("FAIL overlap_off_dout: got %b want 000001000", m[8:0]);
        end
        vectors++;
        if (match_cnt !== 8'd1) begin
            errors++; $display("FAIL overlap_off_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_gaps();
        logic [15:0] m;
        logic o;
        do_reset();
        overlap_en = 1'b0;
        send(16'b001, 3, m);
        for (int g = 0; g < 3; g++) begin
            apply(1'(g & 1), 1'b0, o);
            vectors++;
            if (o !== 1'b0) begin
                errors++; $display("FAIL gap_dout[%0d]: got %b want 0", g, o);
            end
        end
        send(16'b001, 3, m);
        vectors++;
        if (m[2:0] !== 3'b001) begin
            errors++; $display("FAIL gap_match: got %b want 001", m[2:0]);
        end
        vectors++;
        if (match_cnt !== 8'd1) begin
            errors++; $display("FAIL gap_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_load();
        logic [15:0] m;
        do_reset();
        overlap_en = 1'b0;
        @(negedge clk);
        pattern   = 6'b111000;
        pat_load  = 1'b1;
        din       = 1'b1;
        din_valid = 1'b1;
        #1;
        vectors++;
        if (dout !== 1'b0) begin
            errors++; $display("FAIL load_dout: got %b want 0", dout);
        end
        @(posedge clk); #1;
        pat_load = 1'b0;
        send(16'b111000, 6, m);
        vectors++;
        if (m[5:0] !== 6'b000001) begin
            errors++; $display("FAIL load_match: got %b want 000001", m[5:0]);
        end
        send(16'b001001, 6, m);
        vectors++;
        if (m[5:0] !== 6'b000000) begin
            errors++; $display("FAIL load_old_pat: got %b want 000000", m[5:0]);
        end
        vectors++;
        if (match_cnt !== 8'd1) begin
            errors++; $display("FAIL load_cnt: got %0d want 1", match_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic       exp_sat [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        overlap_en2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            din2       = 1'b1;
            din_valid2 = 1'b1;
            @(posedge clk); #1;
            vectors++;
            if (match_cnt2 !== exp_cnt[i] || cnt_sat2 !== exp_sat[i]) begin
                errors++;
                $display("FAIL sat_step[%0d]: got cnt=%0d sat=%b want cnt=%0d sat=%b",
                         i, match_cnt2, cnt_sat2, exp_cnt[i], exp_sat[i]);
            end
        end
        @(negedge clk);
        din_valid2 = 1'b0;
    endtask

    task automatic test_rst_mid();
        logic [15:0] m;
        logic o;
        do_reset();
        overlap_en = 1'b1;
        send(16'b001001, 6, m);
        send(16'b0010, 4, m);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (match_cnt !== 8'd0 || dout_q !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: got cnt=%0d dout_q=%b want 0/0", match_cnt, dout_q);
        end
        @(negedge clk);
        rst = 1'b1;
        // Old prefix 0010 followed by "01" would match 001001 had it survived.
        send(16'b01, 2, m);
        vectors++;
        if (m[1:0] !== 2'b00) begin
            errors++; $display("FAIL rst_mid_stale: got %b want 00", m[1:0]);
        end
        apply(1'b0, 1'b0, o);
        do_reset();
        send(16'b0010, 4, m);
        rst = 1'b0;
        #2 rst = 1'b1;
        send(16'b001001, 6, m);
        vectors++;
        if (m[5:0] !== 6'b000001) begin
            errors++; $display("FAIL rst_mid_resend: got %b want 000001", m[5:0]);
        end
        vectors++;
        if (match_cnt !== 8'd1) begin
            errors++; $display("FAIL rst_mid_cnt: got %0d want 1", match_cnt);
        end
    endtask

    initial begin
        rst         = 1'b0;
        din         = 1'b0;
        din_valid   = 1'b0;
        pattern     = 6'b0;
        pat_load    = 1'b0;
        overlap_en  = 1'b0;
        din2        = 1'b0;
        din_valid2  = 1'b0;
        pattern2    = 2'b0;
        pat_load2   = 1'b0;
        overlap_en2 = 1'b0;

        test_reset();
        test_basic();
        test_overlap();
        test_gaps();
        test_load();
        test_saturate();
        test_rst_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
